// File: rtl/edge_evt_sched.sv
// Multi-channel edge detector feeding a round-robin single-event scheduler.
// Optional per-channel debounce filter: define EDGE_SCHED_DEBOUNCE_EN.
module edge_evt_sched #(
  parameter int unsigned CHN_NUM  = 4,
  parameter int unsigned STAGE    = 2,
  parameter int unsigned DB_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
`ifdef EDGE_SCHED_DEBOUNCE_EN
  input  logic [DB_WIDTH-1:0]        db_thr_i,
`endif
  input  logic [CHN_NUM-1:0]         dat_i,
  input  logic [CHN_NUM-1:0]         en_i,
  input  logic [CHN_NUM-1:0]         re_en_i,
  input  logic [CHN_NUM-1:0]         fe_en_i,
  output logic [CHN_NUM-1:0]         dat_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(CHN_NUM)-1:0] evt_chn_o,
  output logic                       evt_type_o,
  output logic [CHN_NUM-1:0]         ovf_o,
  input  logic                       ovf_clr_i
);

  localparam int unsigned CW = $clog2(CHN_NUM);

  if (CHN_NUM < 2 || CHN_NUM > 32 || STAGE < 2 || DB_WIDTH < 1) begin : g_bad_param
    $error("edge_evt_sched: parameter out of range");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CHN_NUM-1:0] sync_q [STAGE];
  logic [CHN_NUM-1:0] sync_lvl;
  logic [CHN_NUM-1:0] lvl;
  logic [CHN_NUM-1:0] hist_q;
  logic [CHN_NUM-1:0] rise, fall, qual;
  logic [CHN_NUM-1:0] pend_q, typ_q;
  logic [CHN_NUM-1:0] gnt_vec, drop, accept;
  logic [CW-1:0]      ptr_q;
  logic [CW-1:0]      gnt_idx, gnt_try;
  logic               gnt_found, grant, hs;
  int unsigned        scan_j;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < STAGE; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= dat_i;
      for (int unsigned k = 1; k < STAGE; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_lvl = sync_q[STAGE-1];

`ifdef EDGE_SCHED_DEBOUNCE_EN
  logic [CHN_NUM-1:0]  filt_q;
  logic [DB_WIDTH-1:0] cnt_q [CHN_NUM];

  // Level is accepted once it has differed from the filtered value for db_thr_i+1 cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      filt_q <= '0;
      for (int unsigned c = 0; c < CHN_NUM; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < CHN_NUM; c++) begin
        if (sync_lvl[c] == filt_q[c]) begin
          cnt_q[c] <= '0;
        end else if (cnt_q[c] >= db_thr_i) begin
          filt_q[c] <= sync_lvl[c];
          cnt_q[c]  <= '0;
        end else begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_lvl;
`endif

  assign dat_o = lvl;
  assign rise  = ~hist_q & lvl;
  assign fall  = hist_q & ~lvl;
  assign qual  = en_i & ((rise & re_en_i) | (fall & fe_en_i));

  // First pending channel at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_try   = '0;
    scan_j    = 0;
    for (int unsigned i = 0; i < CHN_NUM; i++) begin
      scan_j = 32'(ptr_q) + i;
      if (scan_j >= CHN_NUM) scan_j = scan_j - CHN_NUM;
      gnt_try = CW'(scan_j);
      if (!gnt_found && pend_q[gnt_try]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_try;
      end
    end
  end

  assign grant   = (state_q == IDLE) && gnt_found;
  assign hs      = (state_q == HOLD) && evt_ready_i;
  assign gnt_vec = grant ? (CHN_NUM'(1) << gnt_idx) : '0;
  // A pending slot being granted this cycle is free to take the new edge.
  assign drop    = qual & pend_q & ~gnt_vec;
  assign accept  = qual & ~drop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pend_q) state_d = HOLD;
      HOLD:    if (evt_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign evt_valid_o = (state_q == HOLD);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hist_q     <= '0;
      pend_q     <= '0;
      typ_q      <= '0;
      ovf_o      <= '0;
      ptr_q      <= '0;
      evt_chn_o  <= '0;
      evt_type_o <= 1'b0;
    end else begin
      hist_q <= lvl;
      pend_q <= en_i & (qual | (pend_q & ~gnt_vec));
      typ_q  <= (accept & rise) | (~accept & typ_q);
      ovf_o  <= (ovf_clr_i ? '0 : ovf_o) | drop;
      if (grant) begin
        evt_chn_o  <= gnt_idx;
        evt_type_o <= typ_q[gnt_idx];
      end
      if (hs) ptr_q <= (evt_chn_o == CW'(CHN_NUM - 1)) ? '0 : evt_chn_o + CW'(1);
    end
  end

endmodule

// File: tb/tb_edge_evt_sched.sv
// Self-checking bench for edge_evt_sched: cycle model plus directed scenarios.
module tb_edge_evt_sched;

  localparam int N   = 4;
  localparam int STG = 2;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [N-1:0] dat_i, en_i, re_en_i, fe_en_i;
  logic [N-1:0] dat_o, ovf_o;
  logic         evt_valid_o, evt_ready_i, evt_type_o, ovf_clr_i;
  logic [1:0]   evt_chn_o;
`ifdef EDGE_SCHED_DEBOUNCE_EN
  logic [7:0]   db_thr_i;
`endif

  int checks = 0;
  int errors = 0;

  edge_evt_sched #(.CHN_NUM(N), .STAGE(STG), .DB_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
`ifdef EDGE_SCHED_DEBOUNCE_EN
    .db_thr_i    (db_thr_i),
`endif
    .dat_i       (dat_i),
    .en_i        (en_i),
    .re_en_i     (re_en_i),
    .fe_en_i     (fe_en_i),
    .dat_o       (dat_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_chn_o   (evt_chn_o),
    .evt_type_o  (evt_type_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  bit [N-1:0] m_pipe[$];
  bit [N-1:0] m_hist, m_pend, m_type, m_ovf, m_filt;
  int         m_cnt[N];
  int         m_ptr, m_chn;
  bit         m_hold, m_etype;

  // Observed handshakes
  int hs_n, val_n;
  int hs_chn[$];
  int hs_typ[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pipe.delete();
    for (int k = 0; k < STG; k++) m_pipe.push_back('0);
    m_hist = '0; m_pend = '0; m_type = '0; m_ovf = '0; m_filt = '0;
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
    m_ptr = 0; m_chn = 0; m_hold = 0; m_etype = 0;
  endfunction

  function automatic bit [N-1:0] model_lvl();
`ifdef EDGE_SCHED_DEBOUNCE_EN
    return m_filt;
`else
    return m_pipe[0];
`endif
  endfunction

  function automatic void model_edge();
    bit [N-1:0] lvl, sync, np, nt, no;
    bit r, f, q;
    int g;
    if (!rst_n_i) begin
      model_reset();
      return;
    end
    sync = m_pipe[0];
    lvl  = model_lvl();
    g = -1;
    if (!m_hold) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    np = m_pend; nt = m_type;
    no = ovf_clr_i ? '0 : m_ovf;
    for (int c = 0; c < N; c++) begin
      r = lvl[c] && !m_hist[c];
      f = !lvl[c] && m_hist[c];
      q = en_i[c] && ((r && re_en_i[c]) || (f && fe_en_i[c]));
      if (!en_i[c]) np[c] = 0;
      else if (q) begin
        if (m_pend[c] && g != c) no[c] = 1;
        else begin np[c] = 1; nt[c] = r; end
      end else if (g == c) np[c] = 0;
    end
    if (m_hold) begin
      if (evt_ready_i) begin m_hold = 0; m_ptr = (m_chn + 1) % N; end
    end else if (g >= 0) begin
      m_hold = 1; m_chn = g; m_etype = m_type[g];
    end
    m_pend = np; m_type = nt; m_ovf = no; m_hist = lvl;
`ifdef EDGE_SCHED_DEBOUNCE_EN
    for (int c = 0; c < N; c++) begin
      if (sync[c] == m_filt[c]) m_cnt[c] = 0;
      else if (m_cnt[c] >= int'(db_thr_i)) begin m_filt[c] = sync[c]; m_cnt[c] = 0; end
      else m_cnt[c]++;
    end
`endif
    m_pipe.push_back(dat_i);
    void'(m_pipe.pop_front());
  endfunction

  task automatic step();
    if (evt_valid_o) val_n++;
    if (evt_valid_o && evt_ready_i) begin
      hs_n++;
      hs_chn.push_back(int'(evt_chn_o));
      hs_typ.push_back(int'(evt_type_o));
    end
    @(posedge clk_i);
    model_edge();
    #1;
    chk("dat_o", 32'(dat_o), 32'(model_lvl()));
    chk("valid", 32'(evt_valid_o), 32'(m_hold));
    chk("chn", 32'(evt_chn_o), 32'(m_chn));
    chk("type", 32'(evt_type_o), 32'(m_etype));
    chk("ovf", 32'(ovf_o), 32'(m_ovf));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    hs_n = 0; val_n = 0;
    hs_chn.delete(); hs_typ.delete();
  endtask

  task automatic rst_pulse();
    rst_n_i = 1'b0;
    steps(2);
    rst_n_i = 1'b1;
  endtask

  int ord;

  initial begin
    model_reset();
    rst_n_i = 1'b0; dat_i = '0; en_i = '0; re_en_i = '0; fe_en_i = '0;
    evt_ready_i = 1'b0; ovf_clr_i = 1'b0;
`ifdef EDGE_SCHED_DEBOUNCE_EN
    db_thr_i = '0;
`endif
    steps(3);
    chk("rst_valid", 32'(evt_valid_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    chk("rst_dat", 32'(dat_o), 0);

    // Single rise on channel 1, falls ignored
    rst_n_i = 1'b1; en_i = 4'b0010; re_en_i = 4'b0010; fe_en_i = '0; evt_ready_i = 1'b1;
    steps(2);
    clear_obs();
    dat_i[1] = 1'b1; steps(10);
    dat_i[1] = 1'b0; steps(10);
    chk("039_count", hs_n, 1);
    chk("039_chn", hs_chn.size() > 0 ? hs_chn[0] : -1, 1);
    chk("039_type", hs_typ.size() > 0 ? hs_typ[0] : -1, 1);
    chk("039_valid_cycles", val_n, 1);

    // Simultaneous edges on 0,2,3 from ptr=0; repeat with falls to show ptr back at 0
    rst_pulse();
    en_i = 4'b1111; re_en_i = 4'b1111; fe_en_i = 4'b1111; evt_ready_i = 1'b1;
    clear_obs();
    dat_i = 4'b1101; steps(15);
    ord = hs_chn.size() >= 3 ? hs_chn[0] * 100 + hs_chn[1] * 10 + hs_chn[2] : -1;
    chk("040_count", hs_n, 3);
    chk("040_order", ord, 23);
    clear_obs();
    dat_i = 4'b0000; steps(15);
    ord = hs_chn.size() >= 3 ? hs_chn[0] * 100 + hs_chn[1] * 10 + hs_chn[2] : -1;
    chk("040_ptr_order", ord, 23);
    chk("040_fall_type", hs_typ.size() > 0 ? hs_typ[0] : -1, 0);

    // Channel 2 stalled in HOLD, two further edges -> overflow
    rst_pulse();
    en_i = 4'b0100; re_en_i = 4'b0100; fe_en_i = 4'b0100; evt_ready_i = 1'b0;
    clear_obs();
    dat_i[2] = 1'b1; steps(8);
    chk("041_hold", 32'(evt_valid_o), 1);
    dat_i[2] = 1'b0; steps(5);
    dat_i[2] = 1'b1; steps(5);
    chk("041_ovf", 32'(ovf_o), 32'h4);
    chk("041_chn", 32'(evt_chn_o), 2);
    chk("041_type", 32'(evt_type_o), 1);
    evt_ready_i = 1'b1; steps(10);
    chk("041_count", hs_n, 2);
    chk("041_kept_type", hs_typ.size() > 1 ? hs_typ[1] : -1, 0);

    // Edge in the grant cycle of the same channel
    rst_pulse();
    en_i = 4'b0001; re_en_i = 4'b0001; fe_en_i = 4'b0001; evt_ready_i = 1'b1;
    clear_obs();
    dat_i = 4'b0001; step();
    dat_i = 4'b0000; steps(12);
    chk("042_count", hs_n, 2);
    chk("042_ovf", 32'(ovf_o), 0);
    chk("042_types", hs_typ.size() > 1 ? hs_typ[0] * 10 + hs_typ[1] : -1, 10);

    // Reset during HOLD drops the event
    rst_pulse();
    en_i = 4'b0001; re_en_i = 4'b0001; fe_en_i = '0; evt_ready_i = 1'b0;
    dat_i = 4'b0001; steps(8);
    chk("043_hold", 32'(evt_valid_o), 1);
    rst_n_i = 1'b0; dat_i = '0; step();
    chk("043_valid", 32'(evt_valid_o), 0);
    chk("043_chn", 32'(evt_chn_o), 0);
    rst_n_i = 1'b1; evt_ready_i = 1'b1;
    clear_obs();
    steps(10);
    chk("043_no_replay", hs_n, 0);

    // Inputs held high through reset give one rise per channel
    rst_n_i = 1'b0; dat_i = 4'b1111; en_i = 4'b1111; re_en_i = 4'b1111; fe_en_i = '0;
    steps(3);
    rst_n_i = 1'b1;
    clear_obs();
    steps(20);
    chk("035_count", hs_n, 4);

`ifdef EDGE_SCHED_DEBOUNCE_EN
    rst_pulse();
    db_thr_i = 8'd3; en_i = 4'b0001; re_en_i = 4'b0001; fe_en_i = 4'b0001;
    evt_ready_i = 1'b1; dat_i = '0;
    steps(4);
    clear_obs();
    dat_i = 4'b0001; steps(2);
    dat_i = 4'b0000; steps(12);
    chk("044_glitch", hs_n, 0);
    dat_i = 4'b0001; steps(5);
    dat_i = 4'b0000; steps(15);
    chk("044_pulse", hs_n, 2);
    chk("044_types", hs_typ.size() > 1 ? hs_typ[0] * 10 + hs_typ[1] : -1, 10);
`endif

    // Randomized traffic against the model
    rst_pulse();
    for (int seg = 0; seg < 15; seg++) begin
      en_i    = 4'($urandom | $urandom);
      re_en_i = 4'($urandom);
      fe_en_i = 4'($urandom);
`ifdef EDGE_SCHED_DEBOUNCE_EN
      db_thr_i = 8'($urandom_range(0, 3));
`endif
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 3) == 0) dat_i = dat_i ^ 4'(1 << $urandom_range(0, N - 1));
        evt_ready_i = ($urandom_range(0, 3) != 0);
        ovf_clr_i   = ($urandom_range(0, 15) == 0);
        rst_n_i     = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    ovf_clr_i = 1'b0; rst_n_i = 1'b1;
    steps(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
